// File: rtl/lzd_denorm48_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzd_denorm48_pkg
// Description : Shared constants for the 48-bit right-shift denormalizer.
//               WIDTH/CNTW/NSTAGE describe the fixed datapath; P_MAX is the
//               largest shift that can still leave a nonzero result.
// Revision    : 1.0 - initial release
// ============================================================================
package lzd_denorm48_pkg;

  localparam logic TRUE   = 1'b1;
  localparam logic FALSE  = 1'b0;

  localparam int   WIDTH  = 48;
  localparam int   CNTW   = 6;
  localparam int   NSTAGE = 3;
  localparam int   P_MAX  = WIDTH - 1;

endpackage : lzd_denorm48_pkg
`default_nettype wire

// File: rtl/lzd_denorm48_denorm_stage.sv
`default_nettype none
// ============================================================================
// Module      : denorm_stage
// Description : One pipeline stage of the denormalizer. Shifts the data right
//               by sel*SHIFT_UNIT, where sel is the P_BITS-wide slice of p
//               sitting at bit log2(SHIFT_UNIT), and ORs the dropped bits into
//               the carried sticky. Registers data/sticky/p/nz/valid with a
//               local load-or-hold handshake.
// Ports       : clk, reset          - clock, async active-high reset
//               valid_i / ready_o   - upstream handshake
//               data_i, sticky_i, p_i, nz_i - upstream beat
//               valid_o / ready_i   - downstream handshake
//               data_o, sticky_o, p_o, nz_o - registered beat
// Revision    : 1.0 - initial release
// ============================================================================
module denorm_stage
  import lzd_denorm48_pkg::*;
#(
  parameter int SHIFT_UNIT = 16,
  parameter int P_BITS     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             sticky_i,
  input  logic [CNTW-1:0]  p_i,
  input  logic             nz_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o,
  output logic [CNTW-1:0]  p_o,
  output logic             nz_o
);

  localparam int NOPT  = 1 << P_BITS;
  localparam int P_LSB = $clog2(SHIFT_UNIT);

  logic [NOPT-1:0][WIDTH-1:0] w_shifted;
  logic [NOPT-1:0]            w_dropped;
  logic [P_BITS-1:0]          w_sel;
  logic                       w_load;

  logic [WIDTH-1:0]           data_d;
  logic                       sticky_d;

  logic                       valid_q;
  logic [WIDTH-1:0]           data_q;
  logic                       sticky_q;
  logic [CNTW-1:0]            p_q;
  logic                       nz_q;

  assign w_sel = p_i[P_LSB +: P_BITS];

  // Each candidate shifts data into the upper half of a double-width word; the
  // lower half then holds exactly the bits that fell off, which also covers a
  // full-width shift (everything dropped, result zero).
  generate
    for (genvar i = 0; i < NOPT; i++) begin : g_opt
      logic [2*WIDTH-1:0] w_wide;
      assign w_wide       = {data_i, {WIDTH{1'b0}}} >> (i * SHIFT_UNIT);
      assign w_shifted[i] = w_wide[2*WIDTH-1:WIDTH];
      assign w_dropped[i] = |w_wide[WIDTH-1:0];
    end
  endgenerate

  // A zero-flagged beat is forced to data 0 / sticky 0 regardless of payload.
  always_comb begin
    data_d   = '0;
    sticky_d = 1'b0;
    if (nz_i) begin
      data_d   = w_shifted[w_sel];
      sticky_d = sticky_i | w_dropped[w_sel];
    end
  end

  assign w_load  = !valid_q || ready_i;
  assign ready_o = w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      sticky_q <= 1'b0;
      p_q      <= '0;
      nz_q     <= 1'b0;
    end else if (w_load) begin
      valid_q <= valid_i;
      // Payload only moves with a real beat so a bubble never disturbs it.
      if (valid_i) begin
        data_q   <= data_d;
        sticky_q <= sticky_d;
        p_q      <= p_i;
        nz_q     <= nz_i;
      end
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign sticky_o = sticky_q;
  assign p_o      = p_q;
  assign nz_o     = nz_q;

endmodule : denorm_stage
`default_nettype wire

// File: rtl/lzd_denorm48.sv
`default_nettype none
// ============================================================================
// Module      : lzd_denorm48
// Description : Three-stage pipelined right-shift denormalizer (inverse of the
//               48-bit LZD). out_data = in_mant >> in_p, out_sticky = OR of the
//               shifted-out bits, out_zero = (out_data == 0). Elastic
//               valid/ready, one beat per cycle, 3-cycle latency.
// Ports       : clk, reset                     - clock, async active-high reset
//               in_valid/in_ready              - input handshake
//               in_mant, in_p, in_nz           - mantissa, shift, LZD valid
//               out_valid/out_ready            - output handshake
//               out_data, out_sticky, out_zero - result
// Revision    : 1.0 - initial release
// ============================================================================
module lzd_denorm48
  import lzd_denorm48_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [CNTW-1:0]  in_p,
  input  logic             in_nz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             out_zero
);

  // Index k is the input side of stage k; index NSTAGE is the output port.
  logic             st_valid  [NSTAGE+1];
  logic             st_ready  [NSTAGE+1];
  logic [WIDTH-1:0] st_data   [NSTAGE+1];
  logic             st_sticky [NSTAGE+1];
  logic [CNTW-1:0]  st_p      [NSTAGE+1];
  logic             st_nz     [NSTAGE+1];
  logic             w_p_unused;

  assign st_valid[0]      = in_valid;
  assign st_data[0]       = in_mant;
  assign st_sticky[0]     = FALSE;
  assign st_p[0]          = in_p;
  assign st_nz[0]         = in_nz;
  assign st_ready[NSTAGE] = out_ready;
  assign in_ready         = st_ready[0];

  // Stage k consumes p bits [5-2k:4-2k], i.e. shift units of 16, 4, 1.
  generate
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int SHIFT_UNIT_K = 1 << (2 * (NSTAGE - 1 - k));
      denorm_stage #(
        .SHIFT_UNIT (SHIFT_UNIT_K),
        .P_BITS     (2)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (st_valid[k]),
        .ready_o  (st_ready[k]),
        .data_i   (st_data[k]),
        .sticky_i (st_sticky[k]),
        .p_i      (st_p[k]),
        .nz_i     (st_nz[k]),
        .valid_o  (st_valid[k+1]),
        .ready_i  (st_ready[k+1]),
        .data_o   (st_data[k+1]),
        .sticky_o (st_sticky[k+1]),
        .p_o      (st_p[k+1]),
        .nz_o     (st_nz[k+1])
      );
    end
  endgenerate

  // Every bit of p has been consumed by the time a beat leaves the last stage.
  assign w_p_unused = ^st_p[NSTAGE];

  assign out_valid  = st_valid[NSTAGE];
  assign out_data   = st_data[NSTAGE];
  assign out_sticky = st_sticky[NSTAGE];
  // nz_q is 0 out of reset, so this also gives the reset value of 1.
  assign out_zero   = !st_nz[NSTAGE] || (st_data[NSTAGE] == '0);

endmodule : lzd_denorm48
`default_nettype wire

// File: tb/tb_lzd_denorm48.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzd_denorm48
// Description : Self-checking bench for lzd_denorm48. Directed vector table,
//               random streaming, backpressure and mid-flight reset, with a
//               scoreboard queue filled on input accept and drained on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lzd_denorm48;
  import lzd_denorm48_pkg::*;

  typedef struct packed {
    logic [47:0] data;
    logic        sticky;
    logic        zero;
  } exp_t;

  typedef struct {
    string       name;
    logic [47:0] mant;
    logic [5:0]  p;
    logic        nz;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_mant;
  logic [5:0]  in_p;
  logic        in_nz;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_sticky;
  logic        out_zero;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   stalls   = 0;
  exp_t sb[$];
  exp_t drv_exp;
  exp_t mon_e;
  vec_t tbl[14];

  lzd_denorm48 dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_p       (in_p),
    .in_nz      (in_nz),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: mask-based sticky, separate over-range branch.
  function automatic exp_t model(input logic [47:0] m, input logic [5:0] p, input logic nz);
    exp_t        e;
    logic [47:0] mask;
    if (!nz) begin
      e = '{data: 48'h0, sticky: 1'b0, zero: 1'b1};
    end else if (p >= 6'd48) begin
      e = '{data: 48'h0, sticky: |m, zero: 1'b1};
    end else begin
      mask     = (48'h1 << p) - 48'h1;
      e.data   = m >> p;
      e.sticky = |(m & mask);
      e.zero   = (e.data == 48'h0);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input string n, input logic [47:0] m, input logic [5:0] p,
                         input logic nz, input logic [47:0] d, input logic s, input logic z);
    tbl[i].name = n;
    tbl[i].mant = m;
    tbl[i].p    = p;
    tbl[i].nz   = nz;
    tbl[i].exp  = '{data: d, sticky: s, zero: z};
  endtask

  // Monitor: samples 4 time units after each falling edge, just before the
  // rising edge where the handshakes complete.
  always @(negedge clk) begin
    #4;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got data %0h with empty scoreboard", out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.data));
          check("out_sticky", 64'(out_sticky), 64'(mon_e.sticky));
          check("out_zero", 64'(out_zero), 64'(mon_e.zero));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
    end
  end

  // Offer one beat from a falling edge; return at the falling edge after it
  // was accepted (bounded).
  task automatic send(input logic [47:0] m, input logic [5:0] p, input logic nz, input exp_t e);
    int guard;
    bit acc;
    in_valid = 1'b1;
    in_mant  = m;
    in_p     = p;
    in_nz    = nz;
    drv_exp  = e;
    guard    = 0;
    forever begin
      #4;
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      stalls++;
      guard++;
      if (guard > 100) begin
        n_checks++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected accept", guard);
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Single beat into an empty pipe: out_valid must rise after exactly 3 edges.
  task automatic lat_check(input string n, input logic [47:0] m, input logic [5:0] p, input logic nz);
    in_valid = 1'b1;
    in_mant  = m;
    in_p     = p;
    in_nz    = nz;
    drv_exp  = model(m, p, nz);
    @(posedge clk); #1;
    check({n, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({n, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({n, "_lat3"}, 64'(out_valid), 64'd1);
    @(negedge clk);
  endtask

  initial begin : main
    logic [47:0] m;
    logic [5:0]  p;
    logic        nz;
    logic [47:0] hold;
    logic [47:0] bp_m [5];
    logic [5:0]  bp_p [5];
    int          idx;
    int          out_before;

    set_vec(0,  "identity",   48'h800000000000, 6'd0,  1'b1, 48'h800000000000, 1'b0, 1'b0);
    set_vec(1,  "p47",        48'h800000000000, 6'd47, 1'b1, 48'h000000000001, 1'b0, 1'b0);
    set_vec(2,  "p4_sticky",  48'hC00000000001, 6'd4,  1'b1, 48'h0C0000000000, 1'b1, 1'b0);
    set_vec(3,  "p48",        48'h000000000001, 6'd48, 1'b1, 48'h000000000000, 1'b1, 1'b1);
    set_vec(4,  "nz0",        48'hFFFFFFFFFFFF, 6'd5,  1'b0, 48'h000000000000, 1'b0, 1'b1);
    set_vec(5,  "p63",        48'hFFFFFFFFFFFF, 6'd63, 1'b1, 48'h000000000000, 1'b1, 1'b1);
    set_vec(6,  "p16",        48'hFFFFFFFFFFFF, 6'd16, 1'b1, 48'h0000FFFFFFFF, 1'b1, 1'b0);
    set_vec(7,  "p0_pattern", 48'h123456789ABC, 6'd0,  1'b1, 48'h123456789ABC, 1'b0, 1'b0);
    set_vec(8,  "zero_mant",  48'h000000000000, 6'd10, 1'b1, 48'h000000000000, 1'b0, 1'b1);
    set_vec(9,  "p1",         48'h800000000000, 6'd1,  1'b1, 48'h400000000000, 1'b0, 1'b0);
    set_vec(10, "ones_p47",   48'hFFFFFFFFFFFF, 6'd47, 1'b1, 48'h000000000001, 1'b1, 1'b0);
    set_vec(11, "p51",        48'hA5A5A5A5A5A5, 6'd51, 1'b1, 48'h000000000000, 1'b1, 1'b1);
    set_vec(12, "f0_p4",      48'h0000000000F0, 6'd4,  1'b1, 48'h00000000000F, 1'b0, 1'b0);
    set_vec(13, "f0_p5",      48'h0000000000F0, 6'd5,  1'b1, 48'h000000000007, 1'b1, 1'b0);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_p      = '0;
    in_nz     = 1'b0;
    out_ready = 1'b1;
    drv_exp   = '0;
    repeat (3) @(negedge clk);

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    lat_check("identity", tbl[0].mant, tbl[0].p, tbl[0].nz);
    drain();

    // Directed table, back-to-back.
    foreach (tbl[i]) send(tbl[i].mant, tbl[i].p, tbl[i].nz, tbl[i].exp);
    in_valid = 1'b0;
    drain();

    // Random stream at full rate.
    stalls     = 0;
    out_before = n_out;
    for (int i = 0; i < 100; i++) begin
      m[31:0]  = $urandom;
      m[47:32] = 16'($urandom);
      if (i % 4 == 1) m = m >> $urandom_range(0, 47);
      p  = 6'($urandom_range(0, 63));
      nz = ($urandom_range(0, 9) != 0);
      send(m, p, nz, model(m, p, nz));
    end
    in_valid = 1'b0;
    drain();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_count", 64'(n_out - out_before), 64'd100);

    // Backpressure: 6 cycles with out_ready low while offering 5 beats.
    for (int i = 0; i < 5; i++) begin
      bp_m[i] = 48'h100000000000 * (i + 1) + 48'h3 * i;
      bp_p[i] = 6'(i * 7 + 2);
    end
    out_ready = 1'b0;
    idx       = 0;
    hold      = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      in_mant  = bp_m[idx];
      in_p     = bp_p[idx];
      in_nz    = 1'b1;
      drv_exp  = model(bp_m[idx], bp_p[idx], 1'b1);
      if (cyc == 3) hold = out_data;
      #4;
      if (in_ready) idx++;
      @(negedge clk);
    end
    check("bp_accepted", 64'(idx), 64'd3);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_stable", 64'(out_data), 64'(hold));
    check("bp_hold_value", 64'(hold), 64'(model(bp_m[0], bp_p[0], 1'b1).data));
    out_ready = 1'b1;
    while (idx < 5) begin
      send(bp_m[idx], bp_p[idx], 1'b1, model(bp_m[idx], bp_p[idx], 1'b1));
      idx++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_total_out", 64'(n_out - out_before), 64'd105);

    // Reset with a full pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(48'hFFFF00000000 + 48'(i), 6'd8, 1'b1, model(48'hFFFF00000000 + 48'(i), 6'd8, 1'b1));
    in_valid = 1'b0;
    check("rf_full", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rf_out_valid", 64'(out_valid), 64'd0);
    check("rf_out_zero", 64'(out_zero), 64'd1);
    check("rf_out_data", 64'(out_data), 64'd0);
    sb.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rf_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    lat_check("post_reset", 48'h0000ABCDEF12, 6'd3, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule : tb_lzd_denorm48
`default_nettype wire

// File: doc/lzd_denorm48.md
Name: lzd_denorm48

Overview:
- Pipelined right-shift denormalizer: the inverse of the 48-bit leading-zero detector.
- Takes a normalized 48-bit mantissa and the shift count p that the LZD produced.
- Shifts the mantissa back right by p to restore the original fixed-point magnitude. Also reports lost bits (sticky) and zero.
- Sits after the log/sqrt datapath of the noise generator, where range-reduced values are rescaled. Elastic valid/ready interface, throughput 1 per cycle.

Parameters:
- WIDTH, 48, mantissa/data width. Only 48 is supported; the stage split is fixed.
- CNTW, 6, shift-count width. Must satisfy 2^CNTW >= WIDTH.
- NSTAGE, 3, pipeline depth, fixed. Each stage consumes 2 bits of p.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- in_mant  input  WIDTH  normalized mantissa
- in_p  input  CNTW  right-shift amount (LZD position)
- in_nz  input  1  LZD valid flag; 0 means the original value was zero
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the beat
- out_data  output  WIDTH  in_mant >> in_p, truncated
- out_sticky  output  1  OR of all bits shifted out
- out_zero  output  1  out_data == 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on the port reset.
- Reset values:
  - all stage valids 0, so out_valid = 0
  - out_data = 0, out_sticky = 0, out_zero = 1
  - in_ready = 1 after reset deasserts
- Handshake:
  - A beat transfers on in_valid && in_ready, and on out_valid && out_ready.
  - in_valid may be asserted independently of in_ready.
  - Once out_valid is high, out_data, out_sticky and out_zero stay stable until accepted.
- Stage k register (k = 1..3):
  - loads when its valid is 0 or stage k+1 accepts it this cycle (stage 3's successor is the output port).
  - holds otherwise.
  - in_ready = !s1_valid || s1_advance.
  - Combinational ready ripple is allowed; no skid buffer.
- Stage arithmetic:
  - S1 shifts by {p[5:4],4'b0} (0/16/32/48).
  - S2 shifts by {p[3:2],2'b0} (0/4/8/12).
  - S3 shifts by p[1:0] (0..3).
  - Each stage ORs its dropped bits into a carried sticky.
  - Remaining p bits are carried forward per stage.
- Latency: 3 cycles from input accept to out_valid when out_ready is held high. No bubbles at full rate.
- Boundary conditions:
  - p = 0: out_data = in_mant, sticky = 0.
  - p >= 48 (values 48..63): out_data = 0, sticky = |in_mant.
  - in_nz = 0: out_data = 0, sticky = 0, out_zero = 1, regardless of in_mant and in_p. The beat still occupies a slot and preserves order.
  - in_mant is not required to be normalized; any value is shifted literally.
- Simultaneous events: stage 3 draining and stage 1 loading in the same cycle is legal. A full pipe with out_ready = 1 accepts a new input every cycle.
- Backpressure: out_ready low → pipe fills to 3 beats, then in_ready drops. No beat is lost or duplicated; order is preserved.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared header (alongside TRUE/FALSE):
  - WIDTH = 48, CNTW = 6, NSTAGE = 3
  - P_MAX = 47, the largest shift that can leave a nonzero result
- Sub-module denorm_stage:
  - parameters: SHIFT_UNIT (16/4/1), P_BITS (2)
  - holds: data, sticky, remaining p, nz and valid registers
  - implements: a 4-way shift mux, sticky OR, and the local load/hold logic
  - instantiated 3 times
- Top level: ready chaining and the output zero flag only.

Test Plan:
- Identity: mant=48'h800000000000, p=0, nz=1 → after 3 cycles out_data=48'h800000000000, sticky=0, zero=0.
- Maximum in-range shift: mant=48'h800000000000, p=47 → out_data=48'h000000000001, sticky=0. Then mant=48'hC00000000001, p=4 → out_data=48'h0C0000000000, sticky=1.
- Over-range: mant=48'h000000000001, p=48 → out_data=0, sticky=1, zero=1. With nz=0, mant=48'hFFFFFFFFFFFF, p=5 → out_data=0, sticky=0, zero=1.
- Streaming: 100 random beats back-to-back, out_ready=1 → one output per cycle after 3-cycle latency; each matches the reference model (mant>>p, |dropped bits).
- Backpressure: out_ready=0 for 6 cycles while offering 5 beats → exactly 3 accepted, in_ready=0 afterwards, outputs held stable. Release → beats emerge in order, then the remaining 2 are accepted.
- Reset mid-flight: assert reset with 3 beats in the pipe → out_valid=0 and out_zero=1 immediately. After release, in_ready=1 and the first new beat appears after 3 cycles with no stale data.
